// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache arbiter: the word and line types, plus the
// arbiter FSM state and client identifiers.
package cache_arbiter_pkg;

  typedef logic [31:0]  rv32i_word;
  typedef logic [255:0] llc_cacheline;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    CLIENT_I,
    CLIENT_D
  } arb_client_t;

endpackage

// File: rtl/cache_arbiter.sv
// Two-client round-robin arbiter between the icache and dcache miss ports
// and the single shared cacheline adaptor. One full-line transaction is in
// flight at a time; the winning address, write data and op are latched at
// grant and held until the adaptor responds.
module cache_arbiter
  import cache_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,

  input  logic         i_pmem_read,
  input  logic         i_pmem_write,
  input  logic [31:0]  i_pmem_address,
  input  logic [255:0] i_pmem_wdata,
  output logic [255:0] i_pmem_rdata,
  output logic         i_pmem_resp,

  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [31:0]  d_pmem_address,
  input  logic [255:0] d_pmem_wdata,
  output logic [255:0] d_pmem_rdata,
  output logic         d_pmem_resp,

  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  arb_state_t   state_q, state_d;
  arb_client_t  last_grant_q, last_grant_d;
  logic         mem_read_q, mem_read_d;
  logic         mem_write_q, mem_write_d;
  rv32i_word    mem_address_q, mem_address_d;
  llc_cacheline mem_wdata_q, mem_wdata_d;

  logic i_req, d_req;
  logic grant_i, grant_d;

  assign i_req = i_pmem_read | i_pmem_write;
  assign d_req = d_pmem_read | d_pmem_write;

  // On contention the client that was not granted last time wins.
  assign grant_i = i_req & (~d_req | (last_grant_q == CLIENT_D));
  assign grant_d = d_req & (~i_req | (last_grant_q == CLIENT_I));

  // Next-state, grant latching and completion handling.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d       = SERVE_I;
          last_grant_d  = CLIENT_I;
          mem_address_d = i_pmem_address;
          mem_wdata_d   = i_pmem_wdata;
          mem_write_d   = i_pmem_write;
          mem_read_d    = ~i_pmem_write;
        end else if (grant_d) begin
          state_d       = SERVE_D;
          last_grant_d  = CLIENT_D;
          mem_address_d = d_pmem_address;
          mem_wdata_d   = d_pmem_wdata;
          mem_write_d   = d_pmem_write;
          mem_read_d    = ~d_pmem_write;
        end
      end
      SERVE_I, SERVE_D: begin
        // Always pass through IDLE so the served client can drop its request.
        if (mem_resp) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered adaptor-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= CLIENT_D;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_address  = mem_address_q;
  assign mem_wdata    = mem_wdata_q;

  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;
  assign i_pmem_resp  = (state_q == SERVE_I) & mem_resp;
  assign d_pmem_resp  = (state_q == SERVE_D) & mem_resp;

endmodule
